// File: rtl/fft_pkg.sv
// Shared constants, sample/twiddle types and helpers for the inverse FFT engine.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package fft_pkg;
    localparam int N_POINTS = 64;
    localparam int LOG2_N   = 6;
    localparam int D_W      = 16;
    localparam int TW_W     = 10;
    localparam int TW_FRAC  = TW_W - 2;
    localparam int HALF_N   = N_POINTS / 2;
    localparam int IDX_W    = LOG2_N;
    localparam int BF_W     = LOG2_N - 1;
    localparam int STG_W    = $clog2(LOG2_N);
    // Wide enough for a full-precision complex product sum plus the butterfly add.
    localparam int P_W      = D_W + TW_W + 1;

    localparam logic signed [P_W-1:0] SAT_MAX = P_W'((1 << (D_W - 1)) - 1);
    localparam logic signed [P_W-1:0] SAT_MIN = P_W'(-(1 << (D_W - 1)));

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } ifft_state_t;

    typedef struct packed {
        logic signed [D_W-1:0] re;
        logic signed [D_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW_W-1:0] re;
        logic signed [TW_W-1:0] im;
    } tw_t;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = v[LOG2_N-1-i];
        end
        return r;
    endfunction

    function automatic logic signed [D_W-1:0] sat_d(input logic signed [P_W-1:0] v);
        if (v > SAT_MAX) return {1'b0, {(D_W-1){1'b1}}};
        if (v < SAT_MIN) return {1'b1, {(D_W-1){1'b0}}};
        return D_W'(v);
    endfunction
endpackage

// File: rtl/ImTwiddleMux.sv
// Imaginary part of forward twiddle W[tk] = -sin(2*pi*tk/N), Q2.8, N = 64.
// Latency: combinational.
// Backpressure: none.
module ImTwiddleMux
    import fft_pkg::*;
(
    input  logic [BF_W-1:0]        tk,
    output logic signed [TW_W-1:0] tw
);
    localparam logic signed [TW_W-1:0] NSIN_TAB [HALF_N] = '{
        10'sd0,   -10'sd25,  -10'sd50,  -10'sd74,  -10'sd98,  -10'sd121, -10'sd142, -10'sd162,
       -10'sd181, -10'sd198, -10'sd213, -10'sd226, -10'sd237, -10'sd245, -10'sd251, -10'sd255,
       -10'sd256, -10'sd255, -10'sd251, -10'sd245, -10'sd237, -10'sd226, -10'sd213, -10'sd198,
       -10'sd181, -10'sd162, -10'sd142, -10'sd121, -10'sd98,  -10'sd74,  -10'sd50,  -10'sd25
    };

    assign tw = NSIN_TAB[tk];
endmodule

// File: rtl/ReTwiddleMux.sv
// Real part of forward twiddle W[tk] = cos(2*pi*tk/N), Q2.8, N = 64.
// Latency: combinational.
// Backpressure: none.
module ReTwiddleMux
    import fft_pkg::*;
(
    input  logic [BF_W-1:0]        tk,
    output logic signed [TW_W-1:0] tw
);
    localparam logic signed [TW_W-1:0] COS_TAB [HALF_N] = '{
        10'sd256,  10'sd255,  10'sd251,  10'sd245,  10'sd237,  10'sd226,  10'sd213,  10'sd198,
        10'sd181,  10'sd162,  10'sd142,  10'sd121,  10'sd98,   10'sd74,   10'sd50,   10'sd25,
        10'sd0,   -10'sd25,  -10'sd50,  -10'sd74,  -10'sd98,  -10'sd121, -10'sd142, -10'sd162,
       -10'sd181, -10'sd198, -10'sd213, -10'sd226, -10'sd237, -10'sd245, -10'sd251, -10'sd255
    };

    assign tw = COS_TAB[tk];
endmodule

// File: rtl/ifft_butterfly.sv
// Radix-2 DIT butterfly with conjugated twiddle, 1/2 scaling and saturation.
// Latency: combinational.
// Backpressure: none.
module ifft_butterfly
    import fft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    input  tw_t   w,
    output cplx_t y_top,
    output cplx_t y_bot
);
    logic signed [TW_W-1:0] wc_im;
    logic signed [P_W-1:0]  t_re, t_im, a_re, a_im;

    always_comb begin
        // Most negative code has no positive twin in TW_W bits.
        wc_im = (w.im == {1'b1, {(TW_W-1){1'b0}}}) ? {1'b0, {(TW_W-1){1'b1}}} : -w.im;
        t_re  = (P_W'(b.re) * P_W'(w.re) - P_W'(b.im) * P_W'(wc_im)) >>> TW_FRAC;
        t_im  = (P_W'(b.re) * P_W'(wc_im) + P_W'(b.im) * P_W'(w.re)) >>> TW_FRAC;
        a_re  = P_W'(a.re);
        a_im  = P_W'(a.im);
        y_top.re = sat_d((a_re + t_re) >>> 1);
        y_top.im = sat_d((a_im + t_im) >>> 1);
        y_bot.re = sat_d((a_re - t_re) >>> 1);
        y_bot.im = sat_d((a_im - t_im) >>> 1);
    end
endmodule

// File: rtl/ifft_engine.sv
// In-place radix-2 DIT inverse FFT: serial load, one butterfly/cycle, serial unload.
// Latency: N load + LOG2_N*N/2 compute + N unload cycles per frame.
// Backpressure: in_ready only in LOAD; outputs held while out_valid & ~out_ready.
module ifft_engine
    import fft_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [D_W-1:0] in_re,
    input  logic [D_W-1:0] in_im,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] out_re,
    output logic [D_W-1:0] out_im,
    output logic           out_last,
    output logic           busy
);
    ifft_state_t state;
    logic [IDX_W-1:0] idx;
    logic [BF_W-1:0]  bfly;
    logic [STG_W-1:0] stage;

    logic signed [D_W-1:0] ram_re [N_POINTS];
    logic signed [D_W-1:0] ram_im [N_POINTS];

    logic [BF_W-1:0]  pos, tk;
    logic [IDX_W-1:0] span, top_a, bot_a;
    logic signed [TW_W-1:0] tw_re, tw_im;
    cplx_t a, b, y_top, y_bot;
    tw_t   w;
    logic  in_fire, out_fire, last_bfly;

    always_comb begin
        span  = IDX_W'(1) << stage;
        pos   = bfly & ~({BF_W{1'b1}} << stage);
        top_a = (({1'b0, bfly} >> stage) << (stage + 1'b1)) + {1'b0, pos};
        bot_a = top_a + span;
        tk    = pos << (BF_W - stage);
        a.re  = ram_re[top_a];
        a.im  = ram_im[top_a];
        b.re  = ram_re[bot_a];
        b.im  = ram_im[bot_a];
        w.re  = tw_re;
        w.im  = tw_im;
    end

    ReTwiddleMux u_re_tw (.tk(tk), .tw(tw_re));
    ImTwiddleMux u_im_tw (.tk(tk), .tw(tw_im));

    ifft_butterfly u_bfly (
        .a     (a),
        .b     (b),
        .w     (w),
        .y_top (y_top),
        .y_bot (y_bot)
    );

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == UNLOAD);
    assign busy      = (state != LOAD);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign last_bfly = (bfly == {BF_W{1'b1}});

    assign out_re   = out_valid ? ram_re[idx] : '0;
    assign out_im   = out_valid ? ram_im[idx] : '0;
    assign out_last = out_valid && (idx == IDX_W'(N_POINTS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            idx   <= '0;
            bfly  <= '0;
            stage <= '0;
        end else begin
            case (state)
                LOAD: begin
                    // idx wraps to zero on the last sample, ready for UNLOAD.
                    if (in_fire) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_W'(N_POINTS - 1)) begin
                            state <= COMPUTE;
                            bfly  <= '0;
                            stage <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    bfly <= bfly + 1'b1;
                    if (last_bfly) begin
                        if (stage == STG_W'(LOG2_N - 1)) begin
                            state <= UNLOAD;
                            stage <= '0;
                        end else begin
                            stage <= stage + 1'b1;
                        end
                    end
                end
                UNLOAD: begin
                    if (out_fire) begin
                        idx <= idx + 1'b1;
                        if (idx == IDX_W'(N_POINTS - 1)) state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            ram_re[bitrev(idx)] <= in_re;
            ram_im[bitrev(idx)] <= in_im;
        end else if (state == COMPUTE) begin
            ram_re[top_a] <= y_top.re;
            ram_im[top_a] <= y_top.im;
            ram_re[bot_a] <= y_bot.re;
            ram_im[bot_a] <= y_bot.im;
        end
    end
endmodule

// File: tb/tb_ifft_engine.sv
// Bench for ifft_engine: frames against a floating-twiddle iterative IFFT model.
module tb_ifft_engine;
    localparam int N         = 64;
    localparam int LG        = 6;
    localparam int CYC_LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_re = '0, in_im = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_re, out_im;
    logic        out_last, busy;

    ifft_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int x_re[N], x_im[N], m_re[N], m_im[N], g_re[N], g_im[N];
    int bubbles, lat, nout, last_err, hold_err, rdy_err, mism, first_bad;
    logic post_ready, post_valid, post_last, post_busy;
    logic [15:0] post_re, post_im;

    function automatic int rnd(real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(0.5 - v);
    endfunction

    function automatic int sat16(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int brev(int k);
        int r;
        r = 0;
        for (int i = 0; i < LG; i++) if ((k >> i) & 1) r = r | (1 << (LG - 1 - i));
        return r;
    endfunction

    // Textbook iterative DIT inverse transform, twiddle exp(+j*2*pi*j/len) rounded to Q2.8.
    function automatic void model();
        int ar[N], ai[N];
        int h, p, q, wr, wi, tr, ti, ur, ui;
        real ang;
        for (int k = 0; k < N; k++) begin
            ar[brev(k)] = x_re[k];
            ai[brev(k)] = x_im[k];
        end
        for (int len = 2; len <= N; len = len * 2) begin
            h = len / 2;
            for (int base = 0; base < N; base = base + len) begin
                for (int j = 0; j < h; j++) begin
                    ang = 2.0 * 3.14159265358979 * j / len;
                    wr = rnd(256.0 * $cos(ang));
                    wi = rnd(256.0 * $sin(ang));
                    p = base + j;
                    q = p + h;
                    tr = (ar[q] * wr - ai[q] * wi) >>> 8;
                    ti = (ar[q] * wi + ai[q] * wr) >>> 8;
                    ur = ar[p];
                    ui = ai[p];
                    ar[p] = sat16((ur + tr) >>> 1);
                    ai[p] = sat16((ui + ti) >>> 1);
                    ar[q] = sat16((ur - tr) >>> 1);
                    ai[q] = sat16((ui - ti) >>> 1);
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            m_re[n] = ar[n];
            m_im[n] = ai[n];
        end
    endfunction

    task automatic load_frame();
        bubbles = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (in_ready !== 1'b1) bubbles++;
            in_valid = 1'b1;
            in_re = 16'(x_re[k]);
            in_im = 16'(x_im[k]);
        end
    endtask

    task automatic wait_compute(input bit hold_valid);
        lat = 0;
        rdy_err = 0;
        for (int c = 0; c < CYC_LIMIT; c++) begin
            @(negedge clk);
            in_valid = hold_valid;
            in_re = 16'($urandom);
            in_im = 16'($urandom);
            if (out_valid === 1'b1) break;
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_err++;
            lat++;
        end
    endtask

    task automatic collect_frame(input bit toggle, input bit hold_valid);
        bit stall;
        logic [15:0] pr, pi;
        logic pl;
        stall = 1'b0; pr = '0; pi = '0; pl = 1'b0;
        nout = 0; last_err = 0; hold_err = 0;
        for (int n = 0; n < N; n++) begin
            g_re[n] = 99999;
            g_im[n] = 99999;
        end
        for (int c = 0; c < CYC_LIMIT && nout < N; c++) begin
            if (c != 0) @(negedge clk);
            out_ready = toggle ? c[0] : 1'b1;
            in_valid = hold_valid;
            in_re = 16'($urandom);
            in_im = 16'($urandom);
            if (out_valid === 1'b1) begin
                if (stall && (out_re !== pr || out_im !== pi || out_last !== pl)) hold_err++;
                if (in_ready !== 1'b0 || busy !== 1'b1) rdy_err++;
                if (out_ready) begin
                    g_re[nout] = $signed(out_re);
                    g_im[nout] = $signed(out_im);
                    if (out_last !== (nout == N - 1)) last_err++;
                    nout++;
                end
                stall = !out_ready;
                pr = out_re; pi = out_im; pl = out_last;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        post_ready = in_ready; post_valid = out_valid; post_busy = busy;
        post_re = out_re; post_im = out_im; post_last = out_last;
    endtask

    task automatic run_frame(input bit toggle, input bit hold_valid);
        model();
        load_frame();
        wait_compute(hold_valid);
        collect_frame(toggle, hold_valid);
        mism = 0;
        first_bad = -1;
        for (int n = 0; n < N; n++) begin
            if (g_re[n] != m_re[n] || g_im[n] != m_im[n]) begin
                mism++;
                if (first_bad < 0) first_bad = n;
            end
        end
    endtask

    task automatic clear_x();
        for (int k = 0; k < N; k++) begin
            x_re[k] = 0;
            x_im[k] = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_valid_busy got=%b/%b exp=0/0", out_valid, busy); end
        checks++; if (out_re !== 16'h0 || out_im !== 16'h0 || out_last !== 1'b0) begin failures++; $display("FAIL reset_outputs got=%h/%h/%b exp=0/0/0", out_re, out_im, out_last); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b/%b exp=1/0", in_ready, busy); end
    endtask

    task automatic test_impulse();
        int bad;
        clear_x();
        x_re[0] = 256;
        run_frame(1'b0, 1'b0);
        bad = 0;
        for (int n = 0; n < N; n++) if (g_re[n] != 4 || g_im[n] != 0) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL impulse_all_4 got=%0d bad outputs exp=0", bad); end
        checks++; if (mism != 0) begin failures++; $display("FAIL impulse_model got=%0d mismatches (first n=%0d) exp=0", mism, first_bad); end
        checks++; if (lat != 192) begin failures++; $display("FAIL impulse_latency got=%0d exp=192", lat); end
        checks++; if (bubbles != 0) begin failures++; $display("FAIL impulse_load_bubbles got=%0d exp=0", bubbles); end
        checks++; if (nout != N || last_err != 0) begin failures++; $display("FAIL impulse_count_last got=%0d/%0d exp=64/0", nout, last_err); end
        checks++; if (rdy_err != 0) begin failures++; $display("FAIL impulse_ready_busy got=%0d exp=0", rdy_err); end
        checks++; if (post_ready !== 1'b1 || post_valid !== 1'b0 || post_busy !== 1'b0) begin failures++; $display("FAIL impulse_return_load got=%b/%b/%b exp=1/0/0", post_ready, post_valid, post_busy); end
        checks++; if (post_re !== 16'h0 || post_im !== 16'h0 || post_last !== 1'b0) begin failures++; $display("FAIL impulse_idle_zero got=%h/%h/%b exp=0/0/0", post_re, post_im, post_last); end
    endtask

    task automatic test_dc();
        int bad;
        for (int k = 0; k < N; k++) begin
            x_re[k] = 1024;
            x_im[k] = 0;
        end
        run_frame(1'b0, 1'b0);
        checks++; if (g_re[0] != 1024 || g_im[0] != 0) begin failures++; $display("FAIL dc_x0 got=(%0d,%0d) exp=(1024,0)", g_re[0], g_im[0]); end
        bad = 0;
        for (int n = 1; n < N; n++) if (g_re[n] != 0 || g_im[n] != 0) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL dc_rest_zero got=%0d nonzero exp=0", bad); end
        checks++; if (mism != 0) begin failures++; $display("FAIL dc_model got=%0d mismatches (first n=%0d) exp=0", mism, first_bad); end
    endtask

    task automatic test_conj();
        clear_x();
        x_re[1] = 16384;
        run_frame(1'b0, 1'b0);
        checks++; if (g_re[0] < 254 || g_re[0] > 258 || g_im[0] < -2 || g_im[0] > 2) begin failures++; $display("FAIL conj_x0 got=(%0d,%0d) exp=(256,0)+-2", g_re[0], g_im[0]); end
        checks++; if (g_re[16] < -2 || g_re[16] > 2 || g_im[16] < 254 || g_im[16] > 258) begin failures++; $display("FAIL conj_x16 got=(%0d,%0d) exp=(0,256)+-2", g_re[16], g_im[16]); end
        checks++; if (g_re[48] < -2 || g_re[48] > 2 || g_im[48] < -258 || g_im[48] > -254) begin failures++; $display("FAIL conj_x48 got=(%0d,%0d) exp=(0,-256)+-2", g_re[48], g_im[48]); end
        checks++; if (mism != 0) begin failures++; $display("FAIL conj_model got=%0d mismatches (first n=%0d) exp=0", mism, first_bad); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < N; k++) begin
            x_re[k] = 32767;
            x_im[k] = -32768;
        end
        run_frame(1'b0, 1'b0);
        checks++; if (g_re[0] != 32767 || g_im[0] != -32768) begin failures++; $display("FAIL sat_x0 got=(%0d,%0d) exp=(32767,-32768)", g_re[0], g_im[0]); end
        checks++; if (mism != 0) begin failures++; $display("FAIL sat_model got=%0d mismatches (first n=%0d) exp=0", mism, first_bad); end
    endtask

    task automatic test_random_full_scale();
        logic signed [15:0] r16;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) begin
                r16 = 16'($urandom); x_re[k] = r16;
                r16 = 16'($urandom); x_im[k] = r16;
            end
            run_frame(1'b0, 1'b0);
            checks++; if (mism != 0) begin failures++; $display("FAIL random_model frame=%0d got=%0d mismatches (first n=%0d) exp=0", f, mism, first_bad); end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < N; k++) begin
            x_re[k] = $urandom_range(0, 4000) - 2000;
            x_im[k] = $urandom_range(0, 4000) - 2000;
        end
        run_frame(1'b1, 1'b1);
        checks++; if (mism != 0) begin failures++; $display("FAIL bp_model got=%0d mismatches (first n=%0d) exp=0", mism, first_bad); end
        checks++; if (nout != N) begin failures++; $display("FAIL bp_count got=%0d exp=64", nout); end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL bp_hold got=%0d changes exp=0", hold_err); end
        checks++; if (rdy_err != 0) begin failures++; $display("FAIL bp_in_ready got=%0d exp=0", rdy_err); end
        checks++; if (last_err != 0) begin failures++; $display("FAIL bp_last got=%0d exp=0", last_err); end
        checks++; if (lat != 192) begin failures++; $display("FAIL bp_latency got=%0d exp=192", lat); end
        checks++; if (post_ready !== 1'b1 || post_valid !== 1'b0) begin failures++; $display("FAIL bp_return_load got=%b/%b exp=1/0", post_ready, post_valid); end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) begin
                x_re[k] = $urandom_range(0, 20000) - 10000;
                x_im[k] = $urandom_range(0, 20000) - 10000;
            end
            run_frame(1'b0, 1'b0);
            checks++; if (mism != 0 || bubbles != 0) begin failures++; $display("FAIL b2b_frame%0d got=%0d mismatches/%0d bubbles exp=0/0", f, mism, bubbles); end
        end
    endtask

    task automatic test_reset_mid_compute();
        int bad;
        logic pre_busy;
        clear_x();
        x_re[0] = 256;
        load_frame();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (99) @(negedge clk);
        pre_busy = busy;
        rst = 1'b1;
        #1;
        checks++; if (pre_busy !== 1'b1) begin failures++; $display("FAIL midrst_was_busy got=%b exp=1", pre_busy); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b/%b/%b exp=1/0/0", in_ready, out_valid, busy); end
        checks++; if (out_re !== 16'h0 || out_im !== 16'h0 || out_last !== 1'b0) begin failures++; $display("FAIL midrst_outputs got=%h/%h/%b exp=0/0/0", out_re, out_im, out_last); end
        @(negedge clk);
        rst = 1'b0;
        run_frame(1'b0, 1'b0);
        bad = 0;
        for (int n = 0; n < N; n++) if (g_re[n] != 4 || g_im[n] != 0) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL midrst_impulse got=%0d bad outputs exp=0", bad); end
        checks++; if (lat != 192) begin failures++; $display("FAIL midrst_latency got=%0d exp=192", lat); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_conj();
        test_saturation();
        test_random_full_scale();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_compute();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
